char_plane_writer: RTL and testbench

- Write-side front end for the 15x40 character plane; the VGA pixel path is the read side of that plane.
- Accepts a byte stream (ASCII plus a small set of control codes) over a valid/ready handshake.
- Maintains a text cursor and issues single-cell write strobes (row, col, char id) to the plane's write port.
- Runs a multi-cycle clear sweep on form-feed, so the plane can be driven from a UART receiver or a test sequencer.

---
 rtl/char_plane_writer_pkg.sv | 43 ++++
 rtl/char_plane_writer_if.sv | 23 ++
 rtl/char_plane_writer_text_cursor.sv | 71 +++++++
 rtl/char_plane_writer.sv | 158 +++++++++++++++
 tb/tb_char_plane_writer.sv | 345 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/char_plane_writer_pkg.sv
// Shared constants, control codes and enums for the 15x40 character plane.
// Used by the writer, the plane storage and the VGA pixel path.
package char_plane_pkg;

    localparam int ROW_NUMBER     = 15;
    localparam int COL_NUMBER     = 40;
    localparam int CHAR_ID_LENGTH = 8;
    localparam int ROW_BIT_LEN    = 4;
    localparam int COL_BIT_LEN    = 6;

    localparam logic [CHAR_ID_LENGTH-1:0] BLANK_CHAR = 8'h20;
    localparam logic [CHAR_ID_LENGTH-1:0] PRINT_MIN  = 8'h20;
    localparam logic [CHAR_ID_LENGTH-1:0] CC_BS      = 8'h08;
    localparam logic [CHAR_ID_LENGTH-1:0] CC_LF      = 8'h0A;
    localparam logic [CHAR_ID_LENGTH-1:0] CC_FF      = 8'h0C;
    localparam logic [CHAR_ID_LENGTH-1:0] CC_CR      = 8'h0D;

    localparam logic [ROW_BIT_LEN-1:0] ROW_ZERO = {ROW_BIT_LEN{1'b0}};
    localparam logic [ROW_BIT_LEN-1:0] ROW_ONE  = ROW_BIT_LEN'(32'sd1);
    localparam logic [ROW_BIT_LEN-1:0] ROW_LAST = ROW_BIT_LEN'(ROW_NUMBER - 32'sd1);
    localparam logic [COL_BIT_LEN-1:0] COL_ZERO = {COL_BIT_LEN{1'b0}};
    localparam logic [COL_BIT_LEN-1:0] COL_ONE  = COL_BIT_LEN'(32'sd1);
    localparam logic [COL_BIT_LEN-1:0] COL_LAST = COL_BIT_LEN'(COL_NUMBER - 32'sd1);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } wr_state_e;

    typedef enum logic [2:0] {
        CUR_HOLD   = 3'd0,
        CUR_ADV    = 3'd1,
        CUR_NL     = 3'd2,
        CUR_CR     = 3'd3,
        CUR_BACK   = 3'd4,
        CUR_ORIGIN = 3'd5
    } cur_cmd_e;

    function automatic logic is_printable(input logic [CHAR_ID_LENGTH-1:0] c);
        return (c >= PRINT_MIN);
    endfunction

endpackage

// File: rtl/char_plane_writer_if.sv
// Byte-stream input handshake plus single-cell write port of the character plane.
interface char_plane_writer_if;
    import char_plane_pkg::*;

    logic [CHAR_ID_LENGTH-1:0] in_char;
    logic                      in_valid;
    logic                      in_ready;
    logic                      wr_en;
    logic [ROW_BIT_LEN-1:0]    wr_row;
    logic [COL_BIT_LEN-1:0]    wr_col;
    logic [CHAR_ID_LENGTH-1:0] wr_char;

    modport slave (
        input  in_char, in_valid,
        output in_ready, wr_en, wr_row, wr_col, wr_char
    );

    modport master (
        output in_char, in_valid,
        input  in_ready, wr_en, wr_row, wr_col, wr_char
    );

endinterface

// File: rtl/char_plane_writer_text_cursor.sv
// Text cursor for the character plane: row/col counter with advance, newline,
// carriage return, backspace and return-to-origin; row advance wraps to row 0.
module text_cursor
    import char_plane_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  cur_cmd_e               cmd,
    output logic [ROW_BIT_LEN-1:0] row,
    output logic [COL_BIT_LEN-1:0] col
);

    logic [ROW_BIT_LEN-1:0] row_q, row_d, row_inc_s;
    logic [COL_BIT_LEN-1:0] col_q, col_d;

    // Next cursor position for the requested move.
    always_comb begin
        row_d     = row_q;
        col_d     = col_q;
        row_inc_s = (row_q == ROW_LAST) ? ROW_ZERO : (row_q + ROW_ONE);
        case (cmd)
            CUR_ADV: begin
                if (col_q == COL_LAST) begin
                    col_d = COL_ZERO;
                    row_d = row_inc_s;
                end else begin
                    col_d = col_q + COL_ONE;
                end
            end
            CUR_NL: begin
                col_d = COL_ZERO;
                row_d = row_inc_s;
            end
            CUR_CR: col_d = COL_ZERO;
            CUR_BACK: begin
                if (col_q != COL_ZERO) begin
                    col_d = col_q - COL_ONE;
                end else if (row_q != ROW_ZERO) begin
                    row_d = row_q - ROW_ONE;
                    col_d = COL_LAST;
                end else begin
                    row_d = row_q;
                    col_d = col_q;
                end
            end
            CUR_ORIGIN: begin
                row_d = ROW_ZERO;
                col_d = COL_ZERO;
            end
            default: begin
                row_d = row_q;
                col_d = col_q;
            end
        endcase
    end

    // Cursor registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q <= ROW_ZERO;
            col_q <= COL_ZERO;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    assign row = row_q;
    assign col = col_q;

endmodule

// File: rtl/char_plane_writer.sv
// Write-side front end of the character plane: byte stream in, single-cell writes out.
// Build option CHAR_PLANE_WRITER_CLEAR_ON_RESET_EN: run a full clear sweep after reset.
module char_plane_writer
    import char_plane_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    char_plane_writer_if.slave     bus,
    output logic [ROW_BIT_LEN-1:0] cursor_row,
    output logic [COL_BIT_LEN-1:0] cursor_col,
    output logic                   busy
);

`ifdef CHAR_PLANE_WRITER_CLEAR_ON_RESET_EN
    localparam wr_state_e RST_STATE = CLEAR;
    localparam logic      RST_READY = 1'b0;
    localparam logic      RST_BUSY  = 1'b1;
`else
    localparam wr_state_e RST_STATE = IDLE;
    localparam logic      RST_READY = 1'b1;
    localparam logic      RST_BUSY  = 1'b0;
`endif

    wr_state_e                 state_q, state_d;
    logic [CHAR_ID_LENGTH-1:0] byte_q, byte_d;
    logic                      byte_vld_q, byte_vld_d;
    logic                      in_ready_q, in_ready_d;
    logic                      busy_q, busy_d;
    logic                      wr_en_q, wr_en_d;
    logic [ROW_BIT_LEN-1:0]    wr_row_q, wr_row_d;
    logic [COL_BIT_LEN-1:0]    wr_col_q, wr_col_d;
    logic [CHAR_ID_LENGTH-1:0] wr_char_q, wr_char_d;
    cur_cmd_e                  cur_cmd_s;
    logic                      accept_s;
    logic                      sweep_last_s;

    assign accept_s     = bus.in_valid & in_ready_q;
    assign sweep_last_s = (cursor_row == ROW_LAST) && (cursor_col == COL_LAST);

    text_cursor u_cursor (
        .clk   (clk),
        .rst_n (rst_n),
        .cmd   (cur_cmd_s),
        .row   (cursor_row),
        .col   (cursor_col)
    );

    // Decode the captured byte one cycle after its handshake; sweep one cell per cycle in CLEAR.
    always_comb begin
        state_d    = state_q;
        byte_vld_d = accept_s;
        wr_en_d    = 1'b0;
        wr_row_d   = wr_row_q;
        wr_col_d   = wr_col_q;
        wr_char_d  = wr_char_q;
        cur_cmd_s  = CUR_HOLD;
        if (accept_s) begin
            byte_d = bus.in_char;
        end else begin
            byte_d = byte_q;
        end
        case (state_q)
            IDLE: begin
                if (byte_vld_q) begin
                    case (byte_q)
                        CC_LF: cur_cmd_s = CUR_NL;
                        CC_CR: cur_cmd_s = CUR_CR;
                        CC_FF: begin
                            state_d   = CLEAR;
                            cur_cmd_s = CUR_ORIGIN;
                        end
                        CC_BS: begin
                            if (cursor_col != COL_ZERO) begin
                                wr_en_d   = 1'b1;
                                wr_row_d  = cursor_row;
                                wr_col_d  = cursor_col - COL_ONE;
                                wr_char_d = BLANK_CHAR;
                                cur_cmd_s = CUR_BACK;
                            end else if (cursor_row != ROW_ZERO) begin
                                wr_en_d   = 1'b1;
                                wr_row_d  = cursor_row - ROW_ONE;
                                wr_col_d  = COL_LAST;
                                wr_char_d = BLANK_CHAR;
                                cur_cmd_s = CUR_BACK;
                            end else begin
                                cur_cmd_s = CUR_HOLD;
                            end
                        end
                        default: begin
                            if (is_printable(byte_q)) begin
                                wr_en_d   = 1'b1;
                                wr_row_d  = cursor_row;
                                wr_col_d  = cursor_col;
                                wr_char_d = byte_q;
                                cur_cmd_s = CUR_ADV;
                            end else begin
                                cur_cmd_s = CUR_HOLD;
                            end
                        end
                    endcase
                end else begin
                    cur_cmd_s = CUR_HOLD;
                end
            end
            CLEAR: begin
                wr_en_d   = 1'b1;
                wr_row_d  = cursor_row;
                wr_col_d  = cursor_col;
                wr_char_d = BLANK_CHAR;
                cur_cmd_s = CUR_ADV;
                if (sweep_last_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = CLEAR;
                end
            end
            default: state_d = IDLE;
        endcase
        // Stop accepting as soon as a form-feed is taken, and reopen only one
        // cycle after the final sweep write so the source never races the sweep.
        in_ready_d = (state_q == IDLE) && (state_d == IDLE) &&
                     !(accept_s && (bus.in_char == CC_FF));
        busy_d     = (state_q == CLEAR) || (state_d == CLEAR);
    end

    // State, capture and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RST_STATE;
            byte_q     <= {CHAR_ID_LENGTH{1'b0}};
            byte_vld_q <= 1'b0;
            in_ready_q <= RST_READY;
            busy_q     <= RST_BUSY;
            wr_en_q    <= 1'b0;
            wr_row_q   <= ROW_ZERO;
            wr_col_q   <= COL_ZERO;
            wr_char_q  <= {CHAR_ID_LENGTH{1'b0}};
        end else begin
            state_q    <= state_d;
            byte_q     <= byte_d;
            byte_vld_q <= byte_vld_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
            wr_en_q    <= wr_en_d;
            wr_row_q   <= wr_row_d;
            wr_col_q   <= wr_col_d;
            wr_char_q  <= wr_char_d;
        end
    end

    assign bus.in_ready = in_ready_q;
    assign bus.wr_en    = wr_en_q;
    assign bus.wr_row   = wr_row_q;
    assign bus.wr_col   = wr_col_q;
    assign bus.wr_char  = wr_char_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_char_plane_writer.sv
// Bench for char_plane_writer: table vectors, hand-written sweep/reset sequences and
// random byte streams checked against a linear-position model of the text plane.
module tb_char_plane_writer;
    import char_plane_pkg::*;

`ifdef CHAR_PLANE_WRITER_CLEAR_ON_RESET_EN
    localparam logic RST_READY_EXP = 1'b0;
    localparam logic RST_BUSY_EXP  = 1'b1;
`else
    localparam logic RST_READY_EXP = 1'b1;
    localparam logic RST_BUSY_EXP  = 1'b0;
`endif

    logic                   clk;
    logic                   rst_n;
    logic [ROW_BIT_LEN-1:0] cur_row;
    logic [COL_BIT_LEN-1:0] cur_col;
    logic                   busy;

    char_plane_writer_if bus_if ();

    char_plane_writer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus_if),
        .cursor_row (cur_row),
        .cursor_col (cur_col),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    typedef struct {
        int         r;
        int         c;
        logic [7:0] ch;
    } wr_t;

    wr_t        exp_q[$];
    int         m_row = 0;
    int         m_col = 0;
    int         wr_cnt = 0;
    logic [31:0] last_wr;
    logic [7:0] dut_plane [15][40];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        vectors++;
        if (act !== exp_v) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp_v);
        end
    endtask

    function automatic logic [31:0] pack_cell(input int r, input int c, input logic [7:0] ch);
        return (32'(r) << 16) | (32'(c) << 8) | {24'h000000, ch};
    endfunction

    // Reference: cursor as linear position 0..599 in a row-major 15x40 plane.
    task automatic model_apply(input logic [7:0] b);
        int pos;
        pos = m_row * 40 + m_col;
        if (b == 8'h0A) begin
            m_col = 0;
            m_row = (m_row + 1) % 15;
        end else if (b == 8'h0D) begin
            m_col = 0;
        end else if (b == 8'h08) begin
            if (pos > 0) begin
                pos = pos - 1;
                m_row = pos / 40;
                m_col = pos % 40;
                exp_q.push_back('{m_row, m_col, 8'h20});
            end
        end else if (b == 8'h0C) begin
            for (int p = 0; p < 600; p++) exp_q.push_back('{p / 40, p % 40, 8'h20});
            m_row = 0;
            m_col = 0;
        end else if (b >= 8'h20) begin
            exp_q.push_back('{m_row, m_col, b});
            pos = (pos + 1) % 600;
            m_row = pos / 40;
            m_col = pos % 40;
        end
    endtask

    // Write monitor: every strobe must match the next write the model predicted.
    always @(negedge clk) begin
        if (rst_n && bus_if.wr_en) begin
            wr_t w;
            wr_cnt++;
            last_wr = {12'h000, bus_if.wr_row, 2'b00, bus_if.wr_col, bus_if.wr_char};
            if (bus_if.wr_row < 4'd15 && bus_if.wr_col < 6'd40)
                dut_plane[bus_if.wr_row][bus_if.wr_col] = bus_if.wr_char;
            if (exp_q.size() == 0) begin
                check("unexpected_wr", last_wr, 32'hFFFFFFFF);
            end else begin
                w = exp_q.pop_front();
                check("wr_cell", last_wr, pack_cell(w.r, w.c, w.ch));
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        bus_if.in_char  = b;
        bus_if.in_valid = 1'b1;
        while (!bus_if.in_ready && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 3000) begin
            check("ready_timeout", 32'(n), 32'd0);
            bus_if.in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            bus_if.in_valid = 1'b0;
            model_apply(b);
        end
    endtask

    task automatic settle();
        int n;
        n = 0;
        idle(2);
        while (!bus_if.in_ready && n < 2000) begin
            idle(1);
            n++;
        end
        if (n >= 2000) check("settle_timeout", 32'(n), 32'd0);
        idle(1);
    endtask

    task automatic goto_cell(input int r, input int c);
        send(8'h0D);
        while (m_row != r) send(8'h0A);
        while (m_col != c) send(8'h2E);
        settle();
    endtask

    task automatic check_cursor(input string tag);
        check({tag, "_row"}, {28'h0, cur_row}, 32'(m_row));
        check({tag, "_col"}, {26'h0, cur_col}, 32'(m_col));
    endtask

    typedef struct {
        string      name;
        logic [7:0] ch;
        int         sr, sc, er, ec;
        int         nwr;
        int         wr, wc;
        logic [7:0] wch;
    } vec_t;

    vec_t tbl[14];

    initial begin : watchdog
        #5000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int base, run, first_k, last_k, ready_k, viol, nonblank, k, n;

        tbl[0]  = '{"print_A",    8'h41, 0, 0, 0, 1, 1, 0, 0, 8'h41};
        tbl[1]  = '{"bs_wrap",    8'h08, 2, 0, 1, 39, 1, 1, 39, 8'h20};
        tbl[2]  = '{"bs_origin",  8'h08, 0, 0, 0, 0, 0, 0, 0, 8'h00};
        tbl[3]  = '{"cr",         8'h0D, 5, 17, 5, 0, 0, 0, 0, 8'h00};
        tbl[4]  = '{"lf",         8'h0A, 5, 0, 6, 0, 0, 0, 0, 8'h00};
        tbl[5]  = '{"col_wrap",   8'h7E, 0, 39, 1, 0, 1, 0, 39, 8'h7E};
        tbl[6]  = '{"plane_wrap", 8'h41, 14, 39, 0, 0, 1, 14, 39, 8'h41};
        tbl[7]  = '{"lf_wrap",    8'h0A, 14, 5, 0, 0, 0, 0, 0, 8'h00};
        tbl[8]  = '{"ctrl_01",    8'h01, 3, 3, 3, 3, 0, 0, 0, 8'h00};
        tbl[9]  = '{"hi_byte",    8'hFF, 7, 7, 7, 8, 1, 7, 7, 8'hFF};
        tbl[10] = '{"bs_mid",     8'h08, 4, 10, 4, 9, 1, 4, 9, 8'h20};
        tbl[11] = '{"ctrl_1f",    8'h1F, 9, 0, 9, 0, 0, 0, 0, 8'h00};
        tbl[12] = '{"space",      8'h20, 10, 20, 10, 21, 1, 10, 20, 8'h20};
        tbl[13] = '{"bs_row",     8'h08, 14, 0, 13, 39, 1, 13, 39, 8'h20};

        rst_n           = 1'b0;
        bus_if.in_char  = 8'h00;
        bus_if.in_valid = 1'b0;
        idle(3);
        check("rst_wr_en",    {31'h0, bus_if.wr_en}, 32'd0);
        check("rst_wr_row",   {28'h0, bus_if.wr_row}, 32'd0);
        check("rst_wr_col",   {26'h0, bus_if.wr_col}, 32'd0);
        check("rst_wr_char",  {24'h0, bus_if.wr_char}, 32'd0);
        check("rst_cur_row",  {28'h0, cur_row}, 32'd0);
        check("rst_cur_col",  {26'h0, cur_col}, 32'd0);
        check("rst_in_ready", {31'h0, bus_if.in_ready}, {31'h0, RST_READY_EXP});
        check("rst_busy",     {31'h0, busy}, {31'h0, RST_BUSY_EXP});
        rst_n = 1'b1;
`ifdef CHAR_PLANE_WRITER_CLEAR_ON_RESET_EN
        model_apply(8'h0C);
`endif
        settle();

        // First write appears one cycle after the cycle following the handshake edge.
        bus_if.in_char  = 8'h41;
        bus_if.in_valid = 1'b1;
        idle(1);
        bus_if.in_valid = 1'b0;
        model_apply(8'h41);
        check("lat_n_wr_en",   {31'h0, bus_if.wr_en}, 32'd0);
        check("lat_n_cur_col", {26'h0, cur_col}, 32'd0);
        idle(1);
        check("lat_n1_wr_en",  {31'h0, bus_if.wr_en}, 32'd1);
        check("lat_n1_cell",   {12'h000, bus_if.wr_row, 2'b00, bus_if.wr_col, bus_if.wr_char},
              pack_cell(0, 0, 8'h41));
        check("lat_n1_cur_col", {26'h0, cur_col}, 32'd1);
        idle(1);
        check("lat_n2_wr_en",  {31'h0, bus_if.wr_en}, 32'd0);
        check("hold_wr_char",  {24'h0, bus_if.wr_char}, 32'h41);

        for (int i = 0; i < 14; i++) begin
            goto_cell(tbl[i].sr, tbl[i].sc);
            base = wr_cnt;
            send(tbl[i].ch);
            idle(3);
            check({tbl[i].name, "_row"}, {28'h0, cur_row}, 32'(tbl[i].er));
            check({tbl[i].name, "_col"}, {26'h0, cur_col}, 32'(tbl[i].ec));
            check({tbl[i].name, "_nwr"}, 32'(wr_cnt - base), 32'(tbl[i].nwr));
            if (tbl[i].nwr != 0)
                check({tbl[i].name, "_cell"}, last_wr, pack_cell(tbl[i].wr, tbl[i].wc, tbl[i].wch));
        end

        // Forty printables from the origin fill row 0 and land the cursor on row 1.
        goto_cell(0, 0);
        for (int i = 0; i < 40; i++) send(8'h30 + 8'(i % 10));
        settle();
        check("row_fill_last", last_wr, pack_cell(0, 39, 8'h39));
        check("row_fill_row", {28'h0, cur_row}, 32'd1);
        check("row_fill_col", {26'h0, cur_col}, 32'd0);

        // Form-feed with the next byte held on the bus throughout the sweep.
        goto_cell(3, 5);
        bus_if.in_char  = 8'h0C;
        bus_if.in_valid = 1'b1;
        idle(1);
        model_apply(8'h0C);
        bus_if.in_char = 8'h5A;
        run = 0; first_k = -1; last_k = -1; ready_k = -1; viol = 0; k = 0;
        while (ready_k < 0 && k < 1000) begin
            idle(1);
            if (bus_if.wr_en) begin
                run++;
                if (first_k < 0) first_k = k;
                last_k = k;
                if (!busy || bus_if.in_ready) viol++;
            end
            if (bus_if.in_ready) ready_k = k;
            k++;
        end
        nonblank = 0;
        for (int r = 0; r < 15; r++)
            for (int c = 0; c < 40; c++)
                if (dut_plane[r][c] !== 8'h20) nonblank++;
        check("sweep_count",      32'(run), 32'd600);
        check("sweep_contiguous", 32'(last_k - first_k + 1), 32'(run));
        check("sweep_flags",      32'(viol), 32'd0);
        check("sweep_ready_lag",  32'(ready_k - last_k), 32'd1);
        check("sweep_busy_end",   {31'h0, busy}, 32'd0);
        check("sweep_nonblank",   32'(nonblank), 32'd0);
        check("sweep_cur_row",    {28'h0, cur_row}, 32'd0);
        check("sweep_cur_col",    {26'h0, cur_col}, 32'd0);
        idle(1);
        bus_if.in_valid = 1'b0;
        model_apply(8'h5A);
        idle(3);
        check("held_byte_cell", last_wr, pack_cell(0, 0, 8'h5A));
        check_cursor("held_byte");

        // Random byte stream with idle gaps.
        for (int i = 0; i < 250; i++) begin
            int sel;
            logic [7:0] b;
            sel = int'($urandom_range(0, 99));
            if (sel < 70)      b = 8'($urandom_range(32, 255));
            else if (sel < 78) b = 8'h0A;
            else if (sel < 84) b = 8'h0D;
            else if (sel < 92) b = 8'h08;
            else if (sel < 94) b = 8'h0C;
            else               b = 8'($urandom_range(0, 31));
            send(b);
            idle(int'($urandom_range(0, 2)));
            if (i % 8 == 7) begin
                settle();
                check_cursor("rand");
                check("rand_pending", 32'(exp_q.size()), 32'd0);
            end
        end
        settle();

        // Reset roughly halfway through a sweep.
        send(8'h0C);
        n = 0;
        while (exp_q.size() > 300 && n < 2000) begin
            idle(1);
            n++;
        end
        #3;
        rst_n = 1'b0;
        #1;
        check("abort_wr_en",    {31'h0, bus_if.wr_en}, 32'd0);
        check("abort_wr_row",   {28'h0, bus_if.wr_row}, 32'd0);
        check("abort_wr_col",   {26'h0, bus_if.wr_col}, 32'd0);
        check("abort_wr_char",  {24'h0, bus_if.wr_char}, 32'd0);
        check("abort_cur_row",  {28'h0, cur_row}, 32'd0);
        check("abort_cur_col",  {26'h0, cur_col}, 32'd0);
        check("abort_in_ready", {31'h0, bus_if.in_ready}, {31'h0, RST_READY_EXP});
        check("abort_busy",     {31'h0, busy}, {31'h0, RST_BUSY_EXP});
        exp_q.delete();
        m_row = 0;
        m_col = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
`ifdef CHAR_PLANE_WRITER_CLEAR_ON_RESET_EN
        model_apply(8'h0C);
`endif
        idle(20);
        settle();
        check_cursor("post_abort");
        check("post_abort_ready", {31'h0, bus_if.in_ready}, 32'd1);
        check("final_pending", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
